// File: rtl/cv32e40p_cg_enable_ctrl.sv
// Core clock-gate enable controller.
//
// This block decides when the core clock gate is enabled. A single FSM runs on the free-running
// clock and moves through these states:
//   OFF -> WAKE -> RUN -> DRAIN -> SLEEP -> WAKE -> ...
//
// The state codes are chosen so that each output is one flop of the state register:
//   - clock_en_o is state bit 0.
//   - core_sleep_o is state bit 1.
// The gate enable therefore cannot glitch on a state change.
//
// Parameters:
//   IDLE_HOLD (1..255)  consecutive idle cycles in DRAIN before the clock is gated
//   WAKE_DLY  (1..15)   cycles the clock runs after a wake before core_sleep_o drops
//
// Ports:
//   clk_i           free-running ungated clock
//   rst_ni          asynchronous active-low reset
//   fetch_enable_i  core start request, only looked at in OFF
//   sleep_req_i     core requests sleep (WFI retired)
//   core_busy_i     bus transactions outstanding or pipeline active
//   wake_req_i      pending interrupt or debug request
//   stats_clr_i     synchronous clear of the sleep-cycle counter
//   clock_en_o      enable for the core clock gate
//   core_sleep_o    core asleep or not yet running
//   sleep_cycles_o  cycles spent in SLEEP (saturating)
//
// Optional feature macro: CV32E40P_CG_SLEEP_STATS_EN
//   - Defined: the saturating sleep-cycle counter is built.
//   - Undefined: sleep_cycles_o is tied to 0 and stats_clr_i is ignored.

module cv32e40p_cg_enable_ctrl #(
   parameter int unsigned IDLE_HOLD = 4,
   parameter int unsigned WAKE_DLY  = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        fetch_enable_i,
   input  logic        sleep_req_i,
   input  logic        core_busy_i,
   input  logic        wake_req_i,
   input  logic        stats_clr_i,
   output logic        clock_en_o,
   output logic        core_sleep_o,
   output logic [15:0] sleep_cycles_o
);

   // Bit layout is {disambiguation, core_sleep, clock_en}.
   typedef enum logic [2:0] {
      StOff   = 3'b010,
      StWake  = 3'b011,
      StRun   = 3'b001,
      StDrain = 3'b101,
      StSleep = 3'b110
   } state_e;

   localparam logic [7:0] WakeLoad = 8'(WAKE_DLY - 1);
   localparam logic [7:0] IdleLoad = 8'(IDLE_HOLD - 1);

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StOff;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Every decrement is guarded by cnt_q != 0, so the counter never underflows.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StOff: begin
            if (fetch_enable_i) begin
               state_d = StWake;
               cnt_d   = WakeLoad;
            end
         end
         StWake: begin
            // Wake and sleep requests are deliberately ignored here.
            if (cnt_q == 8'd0) begin
               state_d = StRun;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         StRun: begin
            if (sleep_req_i && !core_busy_i && !wake_req_i) begin
               state_d = StDrain;
               cnt_d   = IdleLoad;
            end
         end
         StDrain: begin
            // Any sign of activity aborts the drain before the count is considered.
            if (wake_req_i || core_busy_i || !sleep_req_i) begin
               state_d = StRun;
            end else if (cnt_q == 8'd0) begin
               state_d = StSleep;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         StSleep: begin
            if (wake_req_i) begin
               state_d = StWake;
               cnt_d   = WakeLoad;
            end
         end
         default: begin
            state_d = StOff;
            cnt_d   = 8'd0;
         end
      endcase
   end

   assign clock_en_o   = state_q[0];
   assign core_sleep_o = state_q[1];

`ifdef CV32E40P_CG_SLEEP_STATS_EN
   logic [15:0] stats_q;

   // Clear takes priority over the increment.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stats_q <= 16'd0;
      end else if (stats_clr_i) begin
         stats_q <= 16'd0;
      end else if ((state_q == StSleep) && (stats_q != 16'hFFFF)) begin
         stats_q <= stats_q + 16'd1;
      end
   end

   assign sleep_cycles_o = stats_q;
`else
   logic unused_stats_clr;
   assign unused_stats_clr = stats_clr_i;
   assign sleep_cycles_o   = 16'd0;
`endif

endmodule

// File: tb/tb_cv32e40p_cg_enable_ctrl.sv
// Directed bench for cv32e40p_cg_enable_ctrl (IDLE_HOLD=4, WAKE_DLY=2).
//
// The driver queues a hand-computed expected output triple for a given cycle. A monitor checks
// each queued entry on the falling edge of the cycle it names.

module tb_cv32e40p_cg_enable_ctrl;

   logic        clk;
   logic        rst_ni;
   logic        fetch_enable_i;
   logic        sleep_req_i;
   logic        core_busy_i;
   logic        wake_req_i;
   logic        stats_clr_i;
   logic        clock_en_o;
   logic        core_sleep_o;
   logic [15:0] sleep_cycles_o;

   cv32e40p_cg_enable_ctrl #(
      .IDLE_HOLD (4),
      .WAKE_DLY  (2)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .fetch_enable_i (fetch_enable_i),
      .sleep_req_i    (sleep_req_i),
      .core_busy_i    (core_busy_i),
      .wake_req_i     (wake_req_i),
      .stats_clr_i    (stats_clr_i),
      .clock_en_o     (clock_en_o),
      .core_sleep_o   (core_sleep_o),
      .sleep_cycles_o (sleep_cycles_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle k spans from rising edge k up to rising edge k+1.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      string       name;
      logic        ce;
      logic        cs;
      logic [15:0] st;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;

   function automatic logic [15:0] sx(input int v);
`ifdef CV32E40P_CG_SLEEP_STATS_EN
      return 16'(v);
`else
      return 16'd0 & 16'(v);
`endif
   endfunction

   task automatic expect_at(input int dc, input string nm, input logic ce, input logic cs,
                            input logic [15:0] st);
      exp_t x;
      x.cyc  = cyc + dc;
      x.name = nm;
      x.ce   = ce;
      x.cs   = cs;
      x.st   = st;
      sb.push_back(x);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         checks++;
         if (e.cyc != cyc) begin
            errors++;
            $display("FAIL %s: not checked at cycle %0d (now %0d)", e.name, e.cyc, cyc);
         end else if ({clock_en_o, core_sleep_o, sleep_cycles_o} !== {e.ce, e.cs, e.st}) begin
            errors++;
            $display("FAIL %s cycle %0d: got ce=%b cs=%b st=%h, want ce=%b cs=%b st=%h",
                     e.name, cyc, clock_en_o, core_sleep_o, sleep_cycles_o, e.ce, e.cs, e.st);
         end
      end
   end

   initial begin
      rst_ni         = 1'b0;
      fetch_enable_i = 1'b0;
      sleep_req_i    = 1'b0;
      core_busy_i    = 1'b0;
      wake_req_i     = 1'b0;
      stats_clr_i    = 1'b0;

      step(2);
      expect_at(0, "reset_out", 1'b0, 1'b1, 16'd0);
      step(1);
      rst_ni = 1'b1;
      expect_at(1, "off_idle1", 1'b0, 1'b1, 16'd0);
      expect_at(3, "off_idle3", 1'b0, 1'b1, 16'd0);
      step(4);

      // Start-up: fetch_enable_i in cycle 0.
      fetch_enable_i = 1'b1;
      expect_at(0, "fetch_c0", 1'b0, 1'b1, 16'd0);
      expect_at(1, "wake_c1", 1'b1, 1'b1, 16'd0);
      expect_at(2, "wake_c2", 1'b1, 1'b1, 16'd0);
      expect_at(3, "run_c3", 1'b1, 1'b0, 16'd0);
      step(1);
      fetch_enable_i = 1'b0;
      expect_at(5, "fetch_drop_run", 1'b1, 1'b0, 16'd0);
      step(6);

      // Sleep entry: DRAIN for four cycles, then gated.
      sleep_req_i = 1'b1;
      expect_at(1, "drain_n1", 1'b1, 1'b0, 16'd0);
      expect_at(4, "drain_n4", 1'b1, 1'b0, 16'd0);
      expect_at(5, "sleep_n5", 1'b0, 1'b1, sx(0));
      expect_at(6, "stats_n6", 1'b0, 1'b1, sx(1));
      step(8);

      // Wake with sleep_req_i still high. WAKE ignores it, and RUN holds while wake is present.
      wake_req_i = 1'b1;
      expect_at(0, "sleep_m0", 1'b0, 1'b1, sx(3));
      expect_at(1, "wake_m1", 1'b1, 1'b1, sx(4));
      expect_at(2, "wake_m2", 1'b1, 1'b1, sx(4));
      expect_at(3, "run_m3", 1'b1, 1'b0, sx(4));
      expect_at(12, "run_both_req", 1'b1, 1'b0, sx(4));
      step(13);

      // Abort in DRAIN via busy; the next entry must count the full hold again.
      wake_req_i = 1'b0;
      expect_at(1, "drain_p1", 1'b1, 1'b0, sx(4));
      step(2);
      core_busy_i = 1'b1;
      expect_at(1, "abort_run", 1'b1, 1'b0, sx(4));
      step(1);
      core_busy_i = 1'b0;
      expect_at(4, "drain_restart", 1'b1, 1'b0, sx(4));
      expect_at(5, "sleep_again", 1'b0, 1'b1, sx(4));
      expect_at(6, "stats_resume", 1'b0, 1'b1, sx(5));
      step(6);

      // Clear during SLEEP beats the increment.
      stats_clr_i = 1'b1;
      expect_at(1, "clr_wins", 1'b0, 1'b1, 16'd0);
      step(1);
      stats_clr_i = 1'b0;
      expect_at(1, "after_clr", 1'b0, 1'b1, sx(1));
      step(2);

      // Wake, re-enter DRAIN, then reset mid-count.
      wake_req_i  = 1'b1;
      sleep_req_i = 1'b0;
      expect_at(1, "wake_q1", 1'b1, 1'b1, sx(3));
      step(1);
      wake_req_i = 1'b0;
      step(2);
      expect_at(0, "run_q3", 1'b1, 1'b0, sx(3));
      sleep_req_i = 1'b1;
      expect_at(1, "drain_q4", 1'b1, 1'b0, sx(3));
      step(2);
      rst_ni      = 1'b0;
      sleep_req_i = 1'b0;
      expect_at(0, "rst_in_drain", 1'b0, 1'b1, 16'd0);
      step(1);
      rst_ni = 1'b1;
      expect_at(1, "off_after_rst1", 1'b0, 1'b1, 16'd0);
      expect_at(3, "off_after_rst3", 1'b0, 1'b1, 16'd0);
      step(4);
      fetch_enable_i = 1'b1;
      expect_at(1, "restart_wake", 1'b1, 1'b1, 16'd0);
      expect_at(3, "restart_run", 1'b1, 1'b0, 16'd0);
      step(1);
      fetch_enable_i = 1'b0;
      step(3);

`ifdef CV32E40P_CG_SLEEP_STATS_EN
      sleep_req_i = 1'b1;
      expect_at(5, "sat_enter", 1'b0, 1'b1, 16'd0);
      step(5 + 70000);
      expect_at(0, "sat_ffff", 1'b0, 1'b1, 16'hFFFF);
      stats_clr_i = 1'b1;
      expect_at(1, "sat_clr", 1'b0, 1'b1, 16'd0);
      step(1);
      stats_clr_i = 1'b0;
      step(1);
`endif

      repeat (20) begin
         if (sb.size() == 0) break;
         @(posedge clk);
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_queue: %0d expectations left, want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
